// File: rtl/uart_int_sched_if.sv
// Groups the interrupt scheduler's bus-side and FIFO-side signals into one bundle.
// Latency: none; wires only.
// Backpressure: none; every strobe is taken in the cycle it is presented.
interface uart_int_sched_if #(
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [3:0]    ier_i;
   logic [1:0]    trg_level_i;
   logic          bit_tick_i;
   logic          rx_push_i;
   logic          rx_pop_i;
   logic          tx_push_i;
   logic [CW-1:0] rx_elem_i;
   logic [CW-1:0] tx_elem_i;
   logic          lsr_err_i;
   logic          lsr_rd_i;
   logic          iir_rd_i;
   logic [3:0]    iir_o;
   logic          irq_o;
   logic          cti_o;

   // Driving side: register file and FIFO status sources.
   modport master (
      output ier_i, trg_level_i, bit_tick_i, rx_push_i, rx_pop_i, tx_push_i,
             rx_elem_i, tx_elem_i, lsr_err_i, lsr_rd_i, iir_rd_i,
      input  iir_o, irq_o, cti_o
   );

   // Scheduler side.
   modport slave (
      input  ier_i, trg_level_i, bit_tick_i, rx_push_i, rx_pop_i, tx_push_i,
             rx_elem_i, tx_elem_i, lsr_err_i, lsr_rd_i, iir_rd_i,
      output iir_o, irq_o, cti_o
   );
endinterface

// File: rtl/uart_int_sched.sv
// 16550-style interrupt prioritiser: tracks line-status, RX data, RX timeout and THR-empty sources.
// Latency: 1 cycle from a pending-source change to iir_o; irq_o follows iir_o combinationally.
// Backpressure: none; strobes are consumed every cycle, nothing stalls.
module uart_int_sched #(
   parameter int FIFO_DEPTH = 16,
   parameter int CHAR_BITS  = 10,
   parameter int TO_CHARS   = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   uart_int_sched_if.slave sif
);
   localparam int            TO_MAX   = TO_CHARS * CHAR_BITS;
   localparam int            TW       = $clog2(TO_MAX + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(TO_MAX);

   typedef enum logic [3:0] {
      IIR_NONE = 4'b0001,
      IIR_LS   = 4'b0110,
      IIR_RX   = 4'b0100,
      IIR_TO   = 4'b1100,
      IIR_THRE = 4'b0010
   } iir_e;

   logic [31:0]   trig_cnt;
   logic          rx_data;
   logic          rx_activity;
   logic [TW-1:0] to_cnt;
   logic          cti;
   logic          ls_p;
   logic          thre_p;
   logic          tx_zero;
   logic          tx_zero_q;
   logic          ier1_q;
   logic          thre_set;
   logic          thre_clr;
   iir_e          iir_q;
   iir_e          iir_nxt;

   // RX trigger threshold decode from the 2-bit level select.
   always_comb begin
      trig_cnt = 32'd1;
      case (sif.trg_level_i)
         2'b00: trig_cnt = 32'd1;
         2'b01: trig_cnt = 32'd4;
         2'b10: trig_cnt = 32'd8;
         2'b11: trig_cnt = 32'd14;
         default: trig_cnt = 32'd1;
      endcase
   end

   // RX data is a live level, never latched: it drops as soon as the FIFO drains below trigger.
   assign rx_data     = (32'(sif.rx_elem_i) >= trig_cnt);
   assign rx_activity = sif.rx_push_i | sif.rx_pop_i | (sif.rx_elem_i == '0);

   // Idle-time counter in bit ticks; saturates at the timeout so it can never wrap back to quiet.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         to_cnt <= '0;
      end else if (rx_activity) begin
         to_cnt <= '0;
      end else if (sif.bit_tick_i && (to_cnt != TO_LIMIT)) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   assign cti = (to_cnt == TO_LIMIT);

   // Line-status pending: a new error in the same cycle as an LSR read must not be lost.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ls_p <= 1'b0;
      end else if (sif.lsr_err_i) begin
         ls_p <= 1'b1;
      end else if (sif.lsr_rd_i) begin
         ls_p <= 1'b0;
      end
   end

   // THR empty fires on the TX FIFO draining, or on the enable being turned on while already empty.
   assign tx_zero  = (sif.tx_elem_i == '0);
   assign thre_set = tx_zero & (~tx_zero_q | (sif.ier_i[1] & ~ier1_q));
   assign thre_clr = sif.tx_push_i | (sif.iir_rd_i & (iir_q == IIR_THRE));

   // THR-empty pending plus the history bits its edge detection needs; a clear beats a set.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         thre_p    <= 1'b0;
         tx_zero_q <= 1'b0;
         ier1_q    <= 1'b0;
      end else begin
         tx_zero_q <= tx_zero;
         ier1_q    <= sif.ier_i[1];
         if (thre_clr) begin
            thre_p <= 1'b0;
         end else if (thre_set) begin
            thre_p <= 1'b1;
         end
      end
   end

   // Fixed-priority encode of the enabled sources; masked sources keep their pending state.
   always_comb begin
      iir_nxt = IIR_NONE;
      if (ls_p && sif.ier_i[2]) begin
         iir_nxt = IIR_LS;
      end else if (rx_data && sif.ier_i[0]) begin
         iir_nxt = IIR_RX;
      end else if (cti && sif.ier_i[3]) begin
         iir_nxt = IIR_TO;
      end else if (thre_p && sif.ier_i[1]) begin
         iir_nxt = IIR_THRE;
      end
   end

   // Registered identification code, refreshed every cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         iir_q <= IIR_NONE;
      end else begin
         iir_q <= iir_nxt;
      end
   end

   assign sif.iir_o = iir_q;
   assign sif.irq_o = (iir_q != IIR_NONE);
   assign sif.cti_o = cti;
endmodule

// File: tb/tb_uart_int_sched.sv
// Randomised and directed stimulus for uart_int_sched, scored against a behavioural source model.
// Latency: expected outputs are queued at each clock edge and checked at the following falling edge.
// Backpressure: none; the monitor consumes one expectation per cycle.
module tb_uart_int_sched;
   localparam int TO_MAX = 40;

   typedef struct {
      logic [3:0] iir;
      logic       irq;
      logic       cti;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   exp_t mon_e;

   // Behavioural reference state.
   bit       m_ls;
   bit       m_thre;
   int       m_idle;
   bit       m_prev_txz;
   bit       m_prev_ier1;
   bit [3:0] m_iir;

   int trig_tab[4]  = '{1, 4, 8, 14};
   bit [3:0] code_tab[4] = '{4'b0110, 4'b0100, 4'b1100, 4'b0010};

   uart_int_sched_if #(.FIFO_DEPTH(16)) sif ();

   uart_int_sched #(.FIFO_DEPTH(16), .CHAR_BITS(10), .TO_CHARS(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .sif   (sif)
   );

   always #5 clk = ~clk;

   // Advance the reference model by one clock using the inputs the DUT samples at this edge.
   task automatic model_step();
      bit src[4];
      bit [3:0] nxt;
      bit txz;
      exp_t e;
      if (rst) begin
         m_ls = 0; m_thre = 0; m_idle = 0; m_prev_txz = 0; m_prev_ier1 = 0; m_iir = 4'b0001;
      end else begin
         txz    = (sif.tx_elem_i == 0);
         src[0] = m_ls && sif.ier_i[2];
         src[1] = (int'(sif.rx_elem_i) >= trig_tab[sif.trg_level_i]) && sif.ier_i[0];
         src[2] = (m_idle == TO_MAX) && sif.ier_i[3];
         src[3] = m_thre && sif.ier_i[1];
         nxt = 4'b0001;
         for (int i = 3; i >= 0; i--) if (src[i]) nxt = code_tab[i];
         if (sif.tx_push_i || (sif.iir_rd_i && m_iir == 4'b0010)) m_thre = 0;
         else if ((txz && !m_prev_txz) || (txz && sif.ier_i[1] && !m_prev_ier1)) m_thre = 1;
         if (sif.rx_push_i || sif.rx_pop_i || sif.rx_elem_i == 0) m_idle = 0;
         else if (sif.bit_tick_i) m_idle = (m_idle + 1 > TO_MAX) ? TO_MAX : m_idle + 1;
         if (sif.lsr_err_i) m_ls = 1;
         else if (sif.lsr_rd_i) m_ls = 0;
         m_prev_txz  = txz;
         m_prev_ier1 = sif.ier_i[1];
         m_iir       = nxt;
      end
      e.iir = m_iir;
      e.irq = (m_iir != 4'b0001);
      e.cti = (m_idle == TO_MAX);
      sb.push_back(e);
   endtask

   // One clock: model at the edge, then release inputs for change 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clear_strobes();
      sif.bit_tick_i = 0; sif.rx_push_i = 0; sif.rx_pop_i = 0; sif.tx_push_i = 0;
      sif.lsr_err_i = 0; sif.lsr_rd_i = 0; sif.iir_rd_i = 0;
   endtask

   // Monitor: compare every presented output against the oldest queued expectation.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         vectors++;
         if (sif.iir_o !== mon_e.iir || sif.irq_o !== mon_e.irq || sif.cti_o !== mon_e.cti) begin
            miscompares++;
            $display("FAIL scoreboard: got iir=%b irq=%b cti=%b expected iir=%b irq=%b cti=%b at %0t",
                     sif.iir_o, sif.irq_o, sif.cti_o, mon_e.iir, mon_e.irq, mon_e.cti, $time);
         end
      end
   end

   initial begin
      int  rx_n;
      int  tx_n;
      bit  quiet;
      rst = 1;
      clear_strobes();
      sif.ier_i = 4'b0000; sif.trg_level_i = 2'b00; sif.rx_elem_i = '0; sif.tx_elem_i = '0;
      repeat (3) step();
      chk("reset_iir", sif.iir_o, 4'b0001);
      chk("reset_cti", {3'b0, sif.cti_o}, 4'd0);
      rst = 0;
      step();
      chk("post_release_irq", {3'b0, sif.irq_o}, 4'd0);

      // RX trigger at 4 entries, then a pop drops below trigger.
      sif.trg_level_i = 2'b01; sif.ier_i = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         sif.rx_push_i = 1; step();
         sif.rx_push_i = 0; sif.rx_elem_i = 5'(i + 1);
      end
      step();
      chk("rx_trig_iir", sif.iir_o, 4'b0100);
      chk("rx_trig_irq", {3'b0, sif.irq_o}, 4'd1);
      sif.rx_pop_i = 1; step();
      sif.rx_pop_i = 0; sif.rx_elem_i = 5'd3; step();
      chk("rx_pop_iir", sif.iir_o, 4'b0001);

      // RX timeout after 40 ticks, saturation on the 41st, cleared by a pop.
      sif.ier_i = 4'b1000; sif.rx_elem_i = 5'd1;
      for (int i = 0; i < 39; i++) begin
         sif.bit_tick_i = 1; step(); sif.bit_tick_i = 0; step();
      end
      chk("to_39_cti", {3'b0, sif.cti_o}, 4'd0);
      sif.bit_tick_i = 1; step(); sif.bit_tick_i = 0;
      chk("to_40_cti", {3'b0, sif.cti_o}, 4'd1);
      step();
      chk("to_iir", sif.iir_o, 4'b1100);
      sif.bit_tick_i = 1; step(); sif.bit_tick_i = 0;
      chk("to_41_sat", {3'b0, sif.cti_o}, 4'd1);
      sif.rx_pop_i = 1; step(); sif.rx_pop_i = 0; sif.rx_elem_i = '0;
      chk("to_pop_cti", {3'b0, sif.cti_o}, 4'd0);
      step();

      // THR empty and line status interplay.
      sif.ier_i = 4'b0110; sif.tx_push_i = 1; sif.tx_elem_i = 5'd1; step();
      sif.tx_push_i = 0; step();
      sif.tx_elem_i = '0; step(); step();
      chk("thre_iir", sif.iir_o, 4'b0010);
      sif.lsr_err_i = 1; step(); sif.lsr_err_i = 0; step();
      chk("ls_over_thre", sif.iir_o, 4'b0110);
      sif.lsr_rd_i = 1; step(); sif.lsr_rd_i = 0; step();
      chk("ls_cleared", sif.iir_o, 4'b0010);
      sif.iir_rd_i = 1; step(); sif.iir_rd_i = 0; step();
      chk("thre_iir_rd", sif.iir_o, 4'b0001);

      // Coincident set/clear cases.
      sif.lsr_err_i = 1; sif.lsr_rd_i = 1; step(); clear_strobes(); step();
      chk("ls_set_wins", sif.iir_o, 4'b0110);
      sif.lsr_rd_i = 1; step(); sif.lsr_rd_i = 0; step();
      sif.tx_elem_i = 5'd1; step(); step();
      sif.tx_elem_i = '0; sif.tx_push_i = 1; step(); sif.tx_push_i = 0; step(); step();
      chk("thre_clr_wins", sif.iir_o, 4'b0001);

      // Masked line status revealed by enabling it.
      sif.ier_i = 4'b0000; sif.lsr_err_i = 1; step(); sif.lsr_err_i = 0; step(); step();
      chk("ls_masked", sif.iir_o, 4'b0001);
      sif.ier_i = 4'b0100; step();
      chk("ls_unmasked", sif.iir_o, 4'b0110);
      sif.lsr_rd_i = 1; step(); sif.lsr_rd_i = 0; step();

      // Reset in the middle of a saturated timeout.
      sif.ier_i = 4'b1000; sif.rx_elem_i = 5'd2;
      for (int i = 0; i < 40; i++) begin
         sif.bit_tick_i = 1; step(); sif.bit_tick_i = 0; step();
      end
      chk("pre_rst_iir", sif.iir_o, 4'b1100);
      rst = 1; step();
      chk("rst_iir", sif.iir_o, 4'b0001);
      chk("rst_cti", {3'b0, sif.cti_o}, 4'd0);
      chk("rst_irq", {3'b0, sif.irq_o}, 4'd0);
      rst = 0; step();
      chk("rst_release_iir", sif.iir_o, 4'b0001);
      for (int i = 0; i < 39; i++) begin
         sif.bit_tick_i = 1; step(); sif.bit_tick_i = 0; step();
      end
      chk("restart_39", {3'b0, sif.cti_o}, 4'd0);
      sif.bit_tick_i = 1; step(); sif.bit_tick_i = 0;
      chk("restart_40", {3'b0, sif.cti_o}, 4'd1);

      // Randomised traffic with alternating busy and quiet RX windows.
      rx_n = 2; tx_n = 0; quiet = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) quiet = ($urandom_range(0, 1) == 1);
         sif.bit_tick_i = ($urandom_range(0, 1) == 1);
         sif.rx_push_i  = !quiet && ($urandom_range(0, 9) == 0) && (rx_n < 16);
         sif.rx_pop_i   = !quiet && ($urandom_range(0, 9) == 0) && (rx_n > 0);
         sif.tx_push_i  = ($urandom_range(0, 9) == 0);
         sif.lsr_err_i  = ($urandom_range(0, 19) == 0);
         sif.lsr_rd_i   = ($urandom_range(0, 9) == 0);
         sif.iir_rd_i   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) sif.ier_i = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) sif.trg_level_i = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 299) == 0);
         sif.rx_elem_i = 5'(rx_n);
         sif.tx_elem_i = 5'(tx_n);
         step();
         if (sif.rx_push_i) rx_n++;
         if (sif.rx_pop_i) rx_n--;
         if (sif.tx_push_i && tx_n < 16) tx_n++;
         else if (tx_n > 0 && $urandom_range(0, 3) == 0) tx_n--;
      end
      rst = 0;
      clear_strobes();
      step();
      repeat (2) @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/uart_int_sched.md
UART_INT_SCHED -- requirements
Module: uart_int_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, RX/TX FIFO depth; element-count ports are $clog2(FIFO_DEPTH)+1 bits wide.
REQ-002 Parameter CHAR_BITS, default 10, bit ticks per character frame.
REQ-003 Parameter TO_CHARS, default 4, character times of RX idle before a timeout.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  block clock.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 ier_i  input  4  enables: [0] RX data, [1] THR empty, [2] line status, [3] RX timeout.
REQ-008 trg_level_i  input  2  RX trigger select: 00=1, 01=4, 10=8, 11=14 entries.
REQ-009 bit_tick_i  input  1  one-cycle pulse per bit time.
REQ-010 rx_push_i / rx_pop_i  input  1 each  RX FIFO write / read strobes.
REQ-011 tx_push_i  input  1  TX FIFO write strobe.
REQ-012 rx_elem_i / tx_elem_i  input  $clog2(FIFO_DEPTH)+1 each  FIFO occupancy.
REQ-013 lsr_err_i  input  1  one-cycle pulse on overrun, parity, framing or break.
REQ-014 lsr_rd_i / iir_rd_i  input  1 each  bus read strobes of LSR / IIR.
REQ-015 iir_o  output  4  16550 IIR code: 0001 none, 0110 line status, 0100 RX data, 1100 timeout, 0010 THR empty.
REQ-016 irq_o  output  1  interrupt request, high when iir_o != 0001.
REQ-017 cti_o  output  1  raw RX timeout pending flag, unmasked.

Function
REQ-018 Line-status pending (ls_p) SHALL set on lsr_err_i and clear on lsr_rd_i. When both occur in the same cycle, set wins.
REQ-019 RX data condition SHALL be combinational and unlatched: rx_elem_i >= trigger count per REQ-008.
REQ-020 Timeout counter to_cnt SHALL be wide enough to hold TO_CHARS*CHAR_BITS (40 at defaults).
REQ-021 to_cnt SHALL clear to 0 in any cycle with rx_push_i, rx_pop_i or rx_elem_i==0.
REQ-022 Otherwise to_cnt SHALL increment by 1 on bit_tick_i, saturating at TO_CHARS*CHAR_BITS; it SHALL never wrap.
REQ-023 cti_o SHALL be high exactly when to_cnt == TO_CHARS*CHAR_BITS.
REQ-024 THR-empty pending (thre_p) SHALL set in the cycle after tx_elem_i goes from nonzero to 0.
REQ-025 thre_p SHALL also set in the cycle after ier_i[1] rises while tx_elem_i==0.
REQ-026 thre_p SHALL clear on tx_push_i, or on iir_rd_i while iir_o==0010. When a set and a clear occur in the same cycle, clear wins.
REQ-027 Fixed priority, highest first: ls_p&ier[2], RX data&ier[0], cti_o&ier[3], thre_p&ier[1].
REQ-028 iir_o SHALL be registered and updated every cycle from the REQ-027 encoding. Latency from a pending change to iir_o is 1 cycle.
REQ-029 irq_o SHALL be derived from the registered iir_o, adding no extra latency.
REQ-030 iir_rd_i SHALL clear only thre_p. The RX data and timeout sources clear solely through FIFO activity (rx_pop_i, rx_push_i, rx_elem_i==0).
REQ-031 Disabling an enable bit SHALL mask the source without clearing its pending state.

Reset
REQ-032 While rst_i is high at a clk_i edge: iir_o=0001, irq_o=0, cti_o=0, to_cnt=0, ls_p=0, thre_p=0, and the stored previous tx_elem_i zero-flag and previous ier_i[1] are set to 0.
REQ-033 Reset asserted mid-timeout or mid-pending SHALL discard all state. No interrupt is reported in the first cycle after reset release.

Verification
REQ-034 trg=01, ier=0001, push 4 RX entries -> after the 4th push iir_o=0100 and irq_o=1 one cycle later; one pop -> iir_o=0001.
REQ-035 ier=1000, rx_elem=1, 40 bit_tick_i with no push/pop -> cti_o=1 and iir_o=1100; 41st tick keeps to_cnt=40; one rx_pop_i -> cti_o=0 next cycle.
REQ-036 ier=0110, tx_elem 1->0 -> iir_o=0010; lsr_err_i pulse -> iir_o=0110; lsr_rd_i -> iir_o=0010; iir_rd_i -> iir_o=0001.
REQ-037 lsr_err_i and lsr_rd_i in the same cycle -> ls_p stays 1. tx_push_i coincident with the tx_elem 1->0 edge -> thre_p=0.
REQ-038 ier=0000, lsr_err_i pulse, then ier=0100 -> iir_o=0110 one cycle after the enable is written.
REQ-039 rst_i pulse with iir_o=1100 and to_cnt=40 -> iir_o=0001, cti_o=0, irq_o=0; counting restarts from 0.
